// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per request/ack and hands it to decode.
// Optional illegal-opcode trap (HALT state) is compiled in with `define FETCH_ILLEGAL_TRAP_EN.
module fetch_unit #(
    parameter int            AW       = 8,
    parameter int            DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clock,
    input  logic          reset,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] ir,
    output logic [AW-1:0] ir_pc,
    output logic          ir_valid,
    input  logic          ir_ready,
    input  logic          jmp_en,
    input  logic [AW-1:0] jmp_addr,
    output logic          ir_illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HOLD,
        S_HALT
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic [AW-1:0] ir_pc_q, ir_pc_d;
    logic          ir_valid_q, ir_valid_d;
    logic          ir_illegal_q, ir_illegal_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          opc_illegal;

    assign opc_illegal = (mem_rdata[DW-1 -: 4] > 4'd5);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        ir_pc_d      = ir_pc_q;
        ir_valid_d   = ir_valid_q;
        ir_illegal_d = ir_illegal_q;

        case (state_q)
            S_IDLE: begin
                if (jmp_en) pc_d = jmp_addr;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ack) begin
                    if (jmp_en) begin
                        pc_d = jmp_addr;
                    end else begin
                        ir_d    = mem_rdata;
                        ir_pc_d = pc_q;
                        pc_d    = pc_q + AW'(1);
`ifdef FETCH_ILLEGAL_TRAP_EN
                        if (opc_illegal) begin
                            ir_illegal_d = 1'b1;
                            state_d      = S_HALT;
                        end else begin
                            ir_valid_d = 1'b1;
                            state_d    = S_HOLD;
                        end
`else
                        ir_valid_d = 1'b1;
                        state_d    = S_HOLD;
`endif
                    end
                end else if (jmp_en) begin
                    pc_d    = jmp_addr;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The old request must still complete; its data is dropped.
                if (jmp_en)  pc_d = jmp_addr;
                if (mem_ack) state_d = S_FETCH;
            end
            S_HOLD: begin
                if (ir_ready || jmp_en) begin
                    ir_valid_d = 1'b0;
                    state_d    = S_FETCH;
                    if (jmp_en) pc_d = jmp_addr;
                end
            end
            S_HALT: begin
                if (jmp_en) begin
                    ir_illegal_d = 1'b0;
                    pc_d         = jmp_addr;
                    state_d      = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state; DRAIN keeps the old address.
        mem_req_d  = (state_d == S_FETCH) || (state_d == S_DRAIN);
        mem_addr_d = (state_d == S_FETCH) ? pc_d : mem_addr_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= '0;
            ir_pc_q      <= '0;
            ir_valid_q   <= 1'b0;
            ir_illegal_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            ir_pc_q      <= ir_pc_d;
            ir_valid_q   <= ir_valid_d;
            ir_illegal_q <= ir_illegal_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign ir         = ir_q;
    assign ir_pc      = ir_pc_q;
    assign ir_valid   = ir_valid_q;
    assign ir_illegal = ir_illegal_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the fetch/decode/execute control FSM. It owns the program counter and reads one instruction word per fetch from instruction memory through a request/acknowledge handshake. It presents the registered instruction to the decode stage with a valid/ready handshake and accepts jump redirects from the execute stage. Opcode field is instr[DW-1:DW-4]: LD=0, ADD=1, JMP=2, ST=3, CMP=4, JEQ=5.

## Interface
- AW, 8, program counter / memory address width (word-addressed)
- DW, 32, instruction width
- RESET_PC, 0, PC value loaded on reset
- clock  input  1  single clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset
- mem_req  output  1  memory read request
- mem_addr  output  AW  read address; held stable while mem_req=1 and mem_ack=0
- mem_ack  input  1  read data valid this cycle; may assert in the same cycle as mem_req
- mem_rdata  input  DW  instruction word, sampled only when mem_ack=1
- ir  output  DW  fetched instruction
- ir_pc  output  AW  address ir was fetched from
- ir_valid  output  1  ir/ir_pc valid for the decode stage
- ir_ready  input  1  decode stage accepts ir this cycle
- jmp_en  input  1  one-cycle redirect pulse from execute
- jmp_addr  input  AW  redirect target
- ir_illegal  output  1  opcode > 5 was fetched (see Configuration)

## Operation
- States: IDLE, FETCH, DRAIN, HOLD, HALT. Reset enters IDLE.
- IDLE: all outputs 0; next cycle goes to FETCH unconditionally (jmp_en in IDLE loads pc and still goes to FETCH).
- FETCH: mem_req=1, mem_addr=pc.
  - mem_ack=1 and jmp_en=0: ir<=mem_rdata, ir_pc<=pc, pc<=pc+1 (mod 2^AW), go to HOLD.
  - mem_ack=1 and jmp_en=1: discard data, pc<=jmp_addr, stay in FETCH.
  - mem_ack=0 and jmp_en=1: pc<=jmp_addr, go to DRAIN (the in-flight request must complete).
  - mem_ack=0 and jmp_en=0: hold.
- DRAIN: mem_req=1, mem_addr = old address (latched at redirect). On mem_ack, discard data and go to FETCH. A further jmp_en in DRAIN overwrites pc; the last redirect wins.
- HOLD: ir_valid=1; ir/ir_pc stable.
  - ir_ready=1: handshake completes; ir_valid<=0; go to FETCH.
  - jmp_en=1: pc<=jmp_addr; ir_valid<=0; go to FETCH. If ir_ready=1 in the same cycle, the handshake still counts as completed.
- HALT: only when the trap is compiled in (see Configuration).
- Exactly one memory request is outstanding at a time; no prefetch.

## Timing
- Reset values: mem_req=0, mem_addr=0, ir=0, ir_pc=0, ir_valid=0, ir_illegal=0, pc=RESET_PC, state=IDLE.
- First mem_req asserts 1 cycle after reset deasserts (IDLE→FETCH).
- mem_ack in cycle N gives ir_valid=1 in cycle N+1. With a zero-wait memory, one instruction completes every 2 cycles while ir_ready is held high.
- Redirect: a jmp_en in cycle N puts mem_addr=jmp_addr on the first FETCH cycle, which is N+1 unless a drain is required.
- Reset asserted mid-operation: all state returns to reset values immediately. Any in-flight memory response is ignored.
- pc wraps from 2^AW-1 to 0 with no flag.

## Configuration
- FETCH_ILLEGAL_TRAP_EN defined:
  - A fetched opcode greater than 5 loads ir and sets ir_illegal=1 with ir_valid=0, and the state goes to HALT.
  - HALT drives mem_req=0 and stays there until jmp_en, which clears ir_illegal, loads pc, and goes to FETCH.
- FETCH_ILLEGAL_TRAP_EN not defined:
  - ir_illegal is tied to 0.
  - Every word passes to decode unchanged; HALT is unreachable.

## Test plan
- Reset release, zero-wait memory returning 0x1000_0000+addr, ir_ready=1: mem_addr follows 0,1,2,…; ir_valid pulses every 2nd cycle with ir_pc=0,1,2.
- ir_ready=0 for 5 cycles in HOLD: ir_valid and ir stay stable, mem_req=0 throughout; the next fetch starts the cycle after ir_ready=1.
- Memory with 3-wait mem_ack; jmp_en with jmp_addr=0x40 pulsed on the 1st wait cycle: mem_addr holds its old value until ack, the data is discarded and ir_valid stays 0, then the next mem_addr=0x40.
- jmp_en in HOLD with ir_ready=1 in the same cycle: ir_valid=0 next cycle; the next fetch is at jmp_addr.
- pc=0xFF with AW=8: ir_pc=0xFF, and the next mem_addr=0x00.
- Trap compiled in, word 0xF000_0000 fetched: ir_illegal=1, mem_req stays 0 for 10 cycles; jmp_en to 0x10 clears ir_illegal and fetching resumes at 0x10.
